// File: rtl/if_stage_pkg.sv
// Shared payload types for the instruction-fetch to decode boundary.
package if_stage_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned ORDER_W = 64;

    typedef struct packed {
        logic               monitor_valid;
        logic [ORDER_W-1:0] monitor_order;
        logic [XLEN-1:0]    monitor_pc_rdata;
        logic [XLEN-1:0]    monitor_pc_wdata;
    } rvfi_mon_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic            branch_pred;
        logic [XLEN-1:0] predicted_pc;
        rvfi_mon_t       rvfi;
    } if_id_reg_t;

endpackage

// File: rtl/if_stage.sv
// Instruction fetch stage: single-outstanding imem requests, one-entry skid
// buffer for decode stalls, redirect flush with stale-response discard.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h1eceb000
) (
    input  logic             clk,
    input  logic             rst,
    output logic [31:0]      imem_addr,
    output logic [3:0]       imem_rmask,
    input  logic [31:0]      imem_rdata,
    input  logic             imem_resp,
    input  logic             stall,
    input  logic             redirect,
    input  logic [31:0]      redirect_pc,
    input  logic [63:0]      redirect_order,
    output logic [31:0]      inst,
    output if_id_reg_t       if_id_reg
);

    typedef enum logic [1:0] {
        S_REQ     = 2'd0,
        S_WAIT    = 2'd1,
        S_HOLD    = 2'd2,
        S_DISCARD = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic        w_accept;
    logic        w_capture;
    logic        w_drain;
    logic        w_out_valid;

    logic [31:0] r_fetch_pc;
    logic [63:0] r_order;
    logic [31:0] r_buf_inst;
    logic [31:0] r_buf_pc;
    logic [63:0] r_buf_order;
    logic [31:0] r_inst;
    if_id_reg_t  r_out;

    // Static not-taken prediction: every entry predicts fall-through.
    function automatic if_id_reg_t make_entry(input logic [31:0] pc, input logic [63:0] order);
        if_id_reg_t e;
        e.pc                    = pc;
        e.branch_pred           = 1'b0;
        e.predicted_pc          = pc + 32'd4;
        e.rvfi.monitor_valid    = 1'b1;
        e.rvfi.monitor_order    = order;
        e.rvfi.monitor_pc_rdata = pc;
        e.rvfi.monitor_pc_wdata = pc + 32'd4;
        return e;
    endfunction

    assign w_out_valid = r_out.rvfi.monitor_valid;
    assign imem_addr   = r_fetch_pc;
    assign inst        = r_inst;
    assign if_id_reg   = r_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_REQ;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Redirect outranks stall and response in every state.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        w_drain      = 1'b0;
        imem_rmask   = 4'h0;
        case (r_state)
            S_REQ: begin
                if (!rst) begin
                    imem_rmask = 4'hf;
                end
                w_next_state = redirect ? S_DISCARD : S_WAIT;
            end
            S_WAIT: begin
                if (redirect) begin
                    w_next_state = imem_resp ? S_REQ : S_DISCARD;
                end else if (imem_resp) begin
                    if (stall && w_out_valid) begin
                        w_capture    = 1'b1;
                        w_next_state = S_HOLD;
                    end else begin
                        w_accept     = 1'b1;
                        w_next_state = S_REQ;
                    end
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    w_next_state = S_REQ;
                end else if (!stall) begin
                    w_drain      = 1'b1;
                    w_next_state = S_REQ;
                end
            end
            S_DISCARD: begin
                if (imem_resp) begin
                    w_next_state = S_REQ;
                end
            end
            default: w_next_state = S_REQ;
        endcase
    end

    // The skid buffer is meaningful only while in HOLD, so it needs no valid bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc  <= RESET_PC;
            r_order     <= '0;
            r_buf_inst  <= '0;
            r_buf_pc    <= '0;
            r_buf_order <= '0;
            r_inst      <= '0;
            r_out       <= '0;
        end else if (redirect) begin
            r_fetch_pc               <= redirect_pc;
            r_order                  <= redirect_order;
            r_out.rvfi.monitor_valid <= 1'b0;
        end else begin
            if (w_accept || w_capture) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
                r_order    <= r_order + 64'd1;
            end
            if (w_capture) begin
                r_buf_inst  <= imem_rdata;
                r_buf_pc    <= r_fetch_pc;
                r_buf_order <= r_order;
            end
            if (w_accept) begin
                r_out  <= make_entry(r_fetch_pc, r_order);
                r_inst <= imem_rdata;
            end else if (w_drain) begin
                r_out  <= make_entry(r_buf_pc, r_buf_order);
                r_inst <= r_buf_inst;
            end else if (!stall) begin
                r_out.rvfi.monitor_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: responding memory model plus an ordered
// scoreboard of instructions decode is expected to accept.
module tb_if_stage;
    import if_stage_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h1eceb000;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [3:0]  imem_rmask;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [63:0] redirect_order;
    logic [31:0] inst;
    if_id_reg_t  if_id_reg;

    if_stage #(.RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_rmask     (imem_rmask),
        .imem_rdata     (imem_rdata),
        .imem_resp      (imem_resp),
        .stall          (stall),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .redirect_order (redirect_order),
        .inst           (inst),
        .if_id_reg      (if_id_reg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [63:0] order;
        logic [31:0] word;
    } exp_t;

    exp_t        q[$];
    int          checks;
    int          failures;
    logic [31:0] tb_pc;
    logic [63:0] tb_order;
    bit          stale;
    bit          mem_pending;
    int          mem_cnt;
    int          mem_delay;
    logic [31:0] mem_addr;
    int          n_consumed;
    logic [31:0] last_pc;
    logic [63:0] last_order;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5a3c_9613;
    endfunction

    // One clock: observe at negedge, then drive the memory response after posedge.
    task automatic cycle();
        exp_t       e;
        if_id_reg_t x;
        @(negedge clk);
        if (!rst) begin
            if (if_id_reg.rvfi.monitor_valid === 1'b1 && stall === 1'b0) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_output got pc=%h order=%0d with nothing expected",
                             if_id_reg.pc, if_id_reg.rvfi.monitor_order);
                end else begin
                    e = q.pop_front();
                    x = '0;
                    x.pc                    = e.pc;
                    x.branch_pred           = 1'b0;
                    x.predicted_pc          = e.pc + 32'd4;
                    x.rvfi.monitor_valid    = 1'b1;
                    x.rvfi.monitor_order    = e.order;
                    x.rvfi.monitor_pc_rdata = e.pc;
                    x.rvfi.monitor_pc_wdata = e.pc + 32'd4;
                    if (if_id_reg !== x) begin
                        failures++;
                        $display("FAIL if_id_reg got=%h exp=%h", if_id_reg, x);
                    end
                    checks++;
                    if (inst !== e.word) begin
                        failures++;
                        $display("FAIL inst got=%h exp=%h (pc %h)", inst, e.word, e.pc);
                    end
                    n_consumed++;
                    last_pc    = e.pc;
                    last_order = e.order;
                end
            end
            if (imem_rmask !== 4'h0) begin
                checks++;
                if (imem_rmask !== 4'hf || mem_pending || imem_addr !== tb_pc) begin
                    failures++;
                    $display("FAIL request got rmask=%h addr=%h outstanding=%0d exp rmask=f addr=%h outstanding=0",
                             imem_rmask, imem_addr, mem_pending, tb_pc);
                end
                mem_pending = 1'b1;
                mem_cnt     = mem_delay;
                mem_addr    = imem_addr;
            end
            if (redirect) begin
                q.delete();
                tb_pc    = redirect_pc;
                tb_order = redirect_order;
                stale    = mem_pending;
            end else if (imem_resp) begin
                if (stale) begin
                    stale = 1'b0;
                end else begin
                    q.push_back('{tb_pc, tb_order, word_of(tb_pc)});
                    tb_pc    = tb_pc + 32'd4;
                    tb_order = tb_order + 64'd1;
                end
            end
        end
        @(posedge clk);
        #1;
        if (mem_pending && mem_cnt == 0) begin
            imem_resp   = 1'b1;
            imem_rdata  = word_of(mem_addr);
            mem_pending = 1'b0;
        end else begin
            imem_resp  = 1'b0;
            imem_rdata = 32'hdead_beef;
            if (mem_pending) mem_cnt--;
        end
    endtask

    task automatic run_until(input int target, input int budget, input string name);
        for (int i = 0; i < budget && n_consumed < target; i++) cycle();
        checks++;
        if (n_consumed < target) begin
            failures++;
            $display("FAIL %s_timeout consumed=%0d required=%0d", name, n_consumed, target);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; redirect = 1'b0;
        redirect_pc = '0; redirect_order = '0;
        imem_resp = 1'b0; imem_rdata = '0;
        mem_pending = 1'b0; mem_cnt = 0; mem_delay = 0; stale = 1'b0;
        q.delete();
        repeat (3) cycle();
        checks++;
        if (imem_rmask !== 4'h0) begin failures++; $display("FAIL reset_rmask got=%h exp=0", imem_rmask); end
        checks++;
        if (if_id_reg.rvfi.monitor_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", if_id_reg.rvfi.monitor_valid); end
        checks++;
        if (inst !== 32'h0) begin failures++; $display("FAIL reset_inst got=%h exp=0", inst); end
        checks++;
        if (imem_addr !== RESET_PC) begin failures++; $display("FAIL reset_addr got=%h exp=%h", imem_addr, RESET_PC); end
        rst = 1'b0;
        tb_pc = RESET_PC; tb_order = '0; n_consumed = 0;
        #1;
        checks++;
        if (imem_rmask !== 4'hf || imem_addr !== RESET_PC) begin
            failures++;
            $display("FAIL first_request got rmask=%h addr=%h exp rmask=f addr=%h", imem_rmask, imem_addr, RESET_PC);
        end
    endtask

    task automatic test_sequential();
        int start;
        start = n_consumed;
        repeat (7) cycle();
        checks++;
        if (n_consumed - start != 3 || last_pc !== RESET_PC + 32'd8 || last_order !== 64'd2) begin
            failures++;
            $display("FAIL sequential got n=%0d last_pc=%h last_order=%0d exp n=3 pc=%h order=2",
                     n_consumed - start, last_pc, last_order, RESET_PC + 32'd8);
        end
    endtask

    task automatic test_stall();
        logic [31:0] buf_pc;
        logic [63:0] buf_order;
        stall = 1'b1;
        for (int i = 0; i < 20 && q.size() < 2; i++) cycle();
        checks++;
        if (q.size() != 2) begin
            failures++;
            $display("FAIL stall_fill got queued=%0d exp=2", q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                cycle();
                checks++;
                if (imem_rmask !== 4'h0) begin failures++; $display("FAIL hold_rmask got=%h exp=0", imem_rmask); end
                checks++;
                if (inst !== q[0].word || if_id_reg.pc !== q[0].pc || if_id_reg.rvfi.monitor_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL hold_output got inst=%h pc=%h valid=%b exp inst=%h pc=%h valid=1",
                             inst, if_id_reg.pc, if_id_reg.rvfi.monitor_valid, q[0].word, q[0].pc);
                end
            end
            buf_pc    = q[1].pc;
            buf_order = q[1].order;
            stall = 1'b0;
            cycle();
            checks++;
            if (if_id_reg.pc !== buf_pc || if_id_reg.rvfi.monitor_order !== buf_order || inst !== word_of(buf_pc)) begin
                failures++;
                $display("FAIL drain_output got pc=%h order=%0d inst=%h exp pc=%h order=%0d inst=%h",
                         if_id_reg.pc, if_id_reg.rvfi.monitor_order, inst, buf_pc, buf_order, word_of(buf_pc));
            end
            checks++;
            if (imem_rmask !== 4'hf || imem_addr !== buf_pc + 32'd4) begin
                failures++;
                $display("FAIL drain_request got rmask=%h addr=%h exp rmask=f addr=%h", imem_rmask, imem_addr, buf_pc + 32'd4);
            end
        end
        stall = 1'b0;
        run_until(n_consumed + 2, 20, "post_stall");
    endtask

    task automatic test_redirect_wait();
        bit found;
        mem_delay = 2;
        stall = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle();
            if (imem_rmask === 4'hf) found = 1'b1;
        end
        checks++;
        if (!found) begin failures++; $display("FAIL redirect_wait_req_timeout got no request"); end
        cycle();
        redirect = 1'b1; redirect_pc = 32'h1eceb100; redirect_order = 64'd7;
        cycle();
        redirect = 1'b0;
        checks++;
        if (imem_rmask !== 4'h0 || if_id_reg.rvfi.monitor_valid !== 1'b0) begin
            failures++;
            $display("FAIL discard_state got rmask=%h valid=%b exp rmask=0 valid=0", imem_rmask, if_id_reg.rvfi.monitor_valid);
        end
        run_until(n_consumed + 1, 30, "redirect_wait");
        checks++;
        if (last_pc !== 32'h1eceb100 || last_order !== 64'd7) begin
            failures++;
            $display("FAIL redirect_wait_target got pc=%h order=%0d exp pc=1eceb100 order=7", last_pc, last_order);
        end
        mem_delay = 0;
    endtask

    task automatic test_redirect_resp_stall();
        bit found;
        stall = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle();
            if (imem_resp === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found) begin failures++; $display("FAIL redirect_resp_timeout got no response"); end
        redirect = 1'b1; redirect_pc = 32'h1eceb200; redirect_order = 64'd100;
        cycle();
        redirect = 1'b0;
        checks++;
        if (imem_rmask !== 4'hf || imem_addr !== 32'h1eceb200 || if_id_reg.rvfi.monitor_valid !== 1'b0) begin
            failures++;
            $display("FAIL redirect_resp_next got rmask=%h addr=%h valid=%b exp rmask=f addr=1eceb200 valid=0",
                     imem_rmask, imem_addr, if_id_reg.rvfi.monitor_valid);
        end
        repeat (4) cycle();
        stall = 1'b0;
        run_until(n_consumed + 1, 20, "redirect_resp");
        checks++;
        if (last_pc !== 32'h1eceb200 || last_order !== 64'd100) begin
            failures++;
            $display("FAIL redirect_resp_target got pc=%h order=%0d exp pc=1eceb200 order=100", last_pc, last_order);
        end
    endtask

    task automatic test_wrap();
        bit found;
        int target;
        stall = 1'b0;
        redirect = 1'b1; redirect_pc = 32'hffff_fff8; redirect_order = 64'hffff_ffff_ffff_ffff;
        cycle();
        redirect = 1'b0;
        target = n_consumed + 3;
        found = 1'b0;
        for (int i = 0; i < 40 && n_consumed < target; i++) begin
            cycle();
            if (!found && if_id_reg.rvfi.monitor_valid === 1'b1 && if_id_reg.pc === 32'hffff_fffc) begin
                found = 1'b1;
                checks++;
                if (if_id_reg.predicted_pc !== 32'h0 || if_id_reg.rvfi.monitor_pc_wdata !== 32'h0) begin
                    failures++;
                    $display("FAIL wrap_predicted got=%h wdata=%h exp=0", if_id_reg.predicted_pc, if_id_reg.rvfi.monitor_pc_wdata);
                end
            end
        end
        checks++;
        if (!found || last_pc !== 32'h0 || last_order !== 64'd1) begin
            failures++;
            $display("FAIL wrap_seq got seen=%0d last_pc=%h last_order=%0d exp seen=1 pc=0 order=1", found, last_pc, last_order);
        end
    endtask

    task automatic test_back_to_back();
        int          start;
        logic [31:0] r;
        start = n_consumed;
        for (int i = 0; i < 400; i++) begin
            stall     = ($urandom_range(0, 3) == 0);
            mem_delay = $urandom_range(0, 2);
            redirect  = ($urandom_range(0, 19) == 0);
            r = $urandom();
            redirect_pc    = {r[31:2], 2'b00};
            redirect_order = {$urandom(), $urandom()};
            cycle();
        end
        redirect  = 1'b0;
        stall     = 1'b0;
        mem_delay = 0;
        checks++;
        if (n_consumed - start < 40) begin
            failures++;
            $display("FAIL random_throughput got=%0d exp>=40", n_consumed - start);
        end
        run_until(n_consumed + 4, 60, "random_tail");
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_wait();
        test_redirect_resp_stall();
        test_wrap();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h1eceb000: fetch address after reset.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 imem_addr  out  32  fetch address; 4-byte aligned.
REQ-005 imem_rmask  out  4  4'hf for exactly one cycle per request, else 4'h0.
REQ-006 imem_rdata  in  32  instruction word; valid only with imem_resp.
REQ-007 imem_resp  in  1  one-cycle pulse completing the single outstanding request.
REQ-008 stall  in  1  decode cannot accept; hold outputs.
REQ-009 redirect  in  1  flush and refetch from redirect_pc (mispredict/jump from EX).
REQ-010 redirect_pc  in  32  new fetch PC; valid with redirect.
REQ-011 redirect_order  in  64  rvfi order for the first instruction fetched after redirect.
REQ-012 inst  out  32  registered instruction word presented to decode.
REQ-013 if_id_reg  out  if_id_reg_t  registered pc, branch_pred, predicted_pc, rvfi.{monitor_valid, monitor_order, monitor_pc_rdata, monitor_pc_wdata}.

Function
REQ-014 FSM states: REQ (issue request), WAIT (request outstanding), HOLD (word buffered, decode stalled), DISCARD (drop stale response).
REQ-015 REQ: drive imem_rmask=4'hf, imem_addr=fetch_pc for one cycle; next state WAIT.
REQ-016 WAIT, imem_resp=1, stall=0: load output register (inst=imem_rdata, pc=fetch_pc, monitor_valid=1, monitor_order=order); fetch_pc+=4; order+=1; next REQ.
REQ-017 WAIT, imem_resp=1, stall=1, output valid: capture word/pc into one-entry buffer; fetch_pc+=4; order+=1; next HOLD; output register unchanged.
REQ-018 WAIT, imem_resp=1, stall=1, output not valid: load output register as in REQ-016; next REQ.
REQ-019 HOLD: no request issued; when stall=0, buffer moves to output register, buffer clears, next REQ.
REQ-020 stall=1: output register and inst held bit-exact; stall=0 with no new word: output monitor_valid=0 (bubble), other fields don't-care.
REQ-021 Static not-taken prediction: branch_pred=0, predicted_pc=pc+4, monitor_pc_wdata=pc+4, monitor_pc_rdata=pc.
REQ-022 redirect has priority over stall and imem_resp: fetch_pc<=redirect_pc, order<=redirect_order, output monitor_valid<=0, buffer cleared.
REQ-023 redirect in WAIT without same-cycle imem_resp: next DISCARD; in WAIT with same-cycle imem_resp: response dropped, next REQ.
REQ-024 redirect in REQ: request still issued this cycle at the old fetch_pc; next DISCARD.
REQ-025 redirect in HOLD: next REQ.
REQ-026 DISCARD: imem_resp dropped (no output, no pc/order change), next REQ; a further redirect in DISCARD updates fetch_pc/order, state stays DISCARD unless imem_resp same cycle (then REQ).
REQ-027 At most one request outstanding; imem_rmask never asserted in WAIT, HOLD or DISCARD.
REQ-028 PC arithmetic modulo 2^32; 0xFFFFFFFC+4 wraps to 0; order modulo 2^64.

Reset
REQ-029 rst=1: state=REQ, fetch_pc=RESET_PC, order=0, buffer empty, output monitor_valid=0, inst=0, imem_rmask=0 during reset.
REQ-030 First request (imem_addr=RESET_PC) issued in the first cycle after rst deasserts; rst mid-transaction abandons it and the late response is ignored only through the DISCARD rule (state after reset is REQ, so bench holds rst until imem idle).

Verification
REQ-031 Reset, 1-cycle-latency memory, stall=0 -> sequential fetches at 1eceb000, 1eceb004, 1eceb008 with monitor_order 0,1,2, one instruction per 2 cycles.
REQ-032 stall=1 while word in output and second response arrives -> inst held, state HOLD, no rmask; stall=0 -> buffered word (pc+4, order+1) appears next cycle, then request issued.
REQ-033 redirect to 0x1eceb100, redirect_order=7, while WAIT -> stale response dropped, next request at 0x1eceb100, delivered monitor_order=7.
REQ-034 redirect coincident with imem_resp and stall=1 -> no output update, buffer empty, next request at redirect_pc the following cycle.
REQ-035 fetch_pc=0xFFFFFFFC delivered -> next imem_addr=0x00000000, predicted_pc=0x00000000.
